// File: rtl/chess_countdown_pkg.sv
// rtl/chess_countdown_pkg.sv - shared state encoding and BCD digit limits for the chess clock
package chess_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FLAG  = 2'd3
    } state_e;

    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
    localparam logic [3:0] MIN_UNITS_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
    localparam logic [3:0] SEC_UNITS_MAX = 4'd9;

    function automatic logic min_valid(input logic [7:0] m);
        return (m[7:4] <= MIN_TENS_MAX) && (m[3:0] <= MIN_UNITS_MAX);
    endfunction

endpackage

// File: rtl/chess_countdown_bcd_mmss_down.sv
// rtl/chess_countdown_bcd_mmss_down.sv - one player's BCD mm:ss down counter, saturating at 00:00
module bcd_mmss_down
    import chess_countdown_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic [15:0] value,
    output logic        zero
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec && (value_q != 16'h0000)) begin
            // Borrow ripples s1 -> s10 -> m1 -> m10; m10 cannot underflow because 00:00 is excluded.
            if (value_q[3:0] != 4'd0) begin
                value_d[3:0] = value_q[3:0] - 4'd1;
            end else begin
                value_d[3:0] = SEC_UNITS_MAX;
                if (value_q[7:4] != 4'd0) begin
                    value_d[7:4] = value_q[7:4] - 4'd1;
                end else begin
                    value_d[7:4] = SEC_TENS_MAX;
                    if (value_q[11:8] != 4'd0) begin
                        value_d[11:8] = value_q[11:8] - 4'd1;
                    end else begin
                        value_d[11:8]  = MIN_UNITS_MAX;
                        value_d[15:12] = value_q[15:12] - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == 16'h0000);

endmodule

// File: rtl/chess_countdown.sv
// rtl/chess_countdown.sv - two-player chess clock: game FSM and turn handover over two BCD counters
module chess_countdown
    import chess_countdown_pkg::*;
#(
    parameter logic [7:0] INIT_MIN     = 8'h05,
    parameter logic       FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  min,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic        press_a,
    input  logic        press_b,
    input  logic        tick,
    output logic [15:0] time_a,
    output logic [15:0] time_b,
    output logic        active_b,
    output logic        running,
    output logic        flag_a,
    output logic        flag_b
);

    state_e state_q;
    logic   active_b_q;
    logic   running_q;
    logic   flag_a_q;
    logic   flag_b_q;

    logic        zero_a;
    logic        zero_b;
    logic        load_clk;
    logic        dec_a;
    logic        dec_b;
    logic        act_press;
    logic        flag_fall;
    logic [15:0] act_time;

    always_comb begin
        act_time  = active_b_q ? time_b : time_a;
        act_press = active_b_q ? press_b : press_a;
        flag_fall = (state_q == ST_RUN) && tick && (act_time == 16'h0001);
        dec_a     = (state_q == ST_RUN) && tick && !active_b_q;
        dec_b     = (state_q == ST_RUN) && tick && active_b_q;
        // A resume in PAUSE takes precedence, so a coincident load must not touch the times.
        load_clk  = load && min_valid(min) && (state_q != ST_RUN)
                    && !((state_q == ST_PAUSE) && start);
    end

    bcd_mmss_down #(.RESET_VAL({INIT_MIN, 8'h00})) u_clk_a (
        .clk      (clk),
        .reset    (reset),
        .load     (load_clk),
        .load_val ({min, 8'h00}),
        .dec      (dec_a),
        .value    (time_a),
        .zero     (zero_a)
    );

    bcd_mmss_down #(.RESET_VAL({INIT_MIN, 8'h00})) u_clk_b (
        .clk      (clk),
        .reset    (reset),
        .load     (load_clk),
        .load_val ({min, 8'h00}),
        .dec      (dec_b),
        .value    (time_b),
        .zero     (zero_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            active_b_q <= FIRST_PLAYER;
            running_q  <= 1'b0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_clk) begin
                        active_b_q <= FIRST_PLAYER;
                        flag_a_q   <= 1'b0;
                        flag_b_q   <= 1'b0;
                    end else if (start && !zero_a && !zero_b) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flag_fall) begin
                        state_q   <= ST_FLAG;
                        running_q <= 1'b0;
                        if (active_b_q) flag_b_q <= 1'b1;
                        else            flag_a_q <= 1'b1;
                    end else if (act_press) begin
                        active_b_q <= ~active_b_q;
                    end else if (pause) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (load_clk) begin
                        state_q    <= ST_IDLE;
                        active_b_q <= FIRST_PLAYER;
                    end
                end
                ST_FLAG: begin
                    if (load_clk) begin
                        state_q    <= ST_IDLE;
                        active_b_q <= FIRST_PLAYER;
                        flag_a_q   <= 1'b0;
                        flag_b_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign active_b = active_b_q;
    assign running  = running_q;
    assign flag_a   = flag_a_q;
    assign flag_b   = flag_b_q;

endmodule

// File: tb/tb_chess_countdown.sv
// tb/tb_chess_countdown.sv - directed self-checking bench for chess_countdown
module tb_chess_countdown;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  min = 8'h00;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0;
    logic        press_a = 1'b0, press_b = 1'b0, tick = 1'b0;
    logic [15:0] time_a, time_b;
    logic        active_b, running, flag_a, flag_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chess_countdown dut (
        .clk(clk), .reset(reset), .min(min), .load(load), .start(start), .pause(pause),
        .press_a(press_a), .press_b(press_b), .tick(tick),
        .time_a(time_a), .time_b(time_b), .active_b(active_b), .running(running),
        .flag_a(flag_a), .flag_b(flag_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] m);
        min = m; load = 1'b1; step(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        vectors++; if (time_a !== 16'h0500) begin miscompares++; $display("FAIL reset_time_a got=%h exp=0500", time_a); end
        vectors++; if (time_b !== 16'h0500) begin miscompares++; $display("FAIL reset_time_b got=%h exp=0500", time_b); end
        vectors++; if ({active_b, running, flag_a, flag_b} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got=%b exp=0000", {active_b, running, flag_a, flag_b}); end
    endtask

    task automatic test_start_ticks();
        do_load(8'h03);
        vectors++; if (time_b !== 16'h0300) begin miscompares++; $display("FAIL load3_time_b got=%h exp=0300", time_b); end
        do_start();
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL start_running got=%b exp=1", running); end
        do_ticks(3);
        vectors++; if (time_a !== 16'h0257) begin miscompares++; $display("FAIL run3_time_a got=%h exp=0257", time_a); end
        vectors++; if (time_b !== 16'h0300) begin miscompares++; $display("FAIL run3_time_b got=%h exp=0300", time_b); end
        vectors++; if (active_b !== 1'b0) begin miscompares++; $display("FAIL run3_active_b got=%b exp=0", active_b); end
    endtask

    task automatic test_handover();
        press_a = 1'b1; step(); press_a = 1'b0;
        do_ticks(2);
        vectors++; if (time_a !== 16'h0257) begin miscompares++; $display("FAIL hand_time_a got=%h exp=0257", time_a); end
        vectors++; if (time_b !== 16'h0258) begin miscompares++; $display("FAIL hand_time_b got=%h exp=0258", time_b); end
        vectors++; if (active_b !== 1'b1) begin miscompares++; $display("FAIL hand_active_b got=%b exp=1", active_b); end
        press_a = 1'b1; step(); press_a = 1'b0;
        vectors++; if (active_b !== 1'b1) begin miscompares++; $display("FAIL inactive_press got=%b exp=1", active_b); end
        // tick + active press: B decrements, then turn passes to A
        tick = 1'b1; press_b = 1'b1; step(); tick = 1'b0; press_b = 1'b0;
        vectors++; if (time_b !== 16'h0257) begin miscompares++; $display("FAIL tickpress_time_b got=%h exp=0257", time_b); end
        vectors++; if (active_b !== 1'b0) begin miscompares++; $display("FAIL tickpress_active got=%b exp=0", active_b); end
        press_a = 1'b1; press_b = 1'b1; step(); press_a = 1'b0; press_b = 1'b0;
        vectors++; if (active_b !== 1'b1) begin miscompares++; $display("FAIL both_press got=%b exp=1", active_b); end
    endtask

    task automatic test_flag();
        do_reset();
        do_load(8'h01); do_start(); do_ticks(60);
        vectors++; if (time_a !== 16'h0000) begin miscompares++; $display("FAIL flag_time_a got=%h exp=0000", time_a); end
        vectors++; if ({flag_a, flag_b, running} !== 3'b100) begin miscompares++; $display("FAIL flag_state got=%b exp=100", {flag_a, flag_b, running}); end
        do_ticks(2);
        press_a = 1'b1; step(); press_a = 1'b0;
        do_start();
        vectors++; if ({time_a, time_b} !== 32'h0000_0100) begin miscompares++; $display("FAIL flag_hold got=%h exp=00000100", {time_a, time_b}); end
        vectors++; if ({active_b, running, flag_a} !== 3'b001) begin miscompares++; $display("FAIL flag_hold_ctl got=%b exp=001", {active_b, running, flag_a}); end
        do_load(8'h02);
        vectors++; if (time_a !== 16'h0200) begin miscompares++; $display("FAIL flag_reload got=%h exp=0200", time_a); end
        vectors++; if (flag_a !== 1'b0) begin miscompares++; $display("FAIL flag_clear got=%b exp=0", flag_a); end
        // flag-fall beats a simultaneous press
        do_load(8'h01); do_start(); do_ticks(59);
        vectors++; if (time_a !== 16'h0001) begin miscompares++; $display("FAIL pre_fall got=%h exp=0001", time_a); end
        tick = 1'b1; press_a = 1'b1; step(); tick = 1'b0; press_a = 1'b0;
        vectors++; if ({flag_a, active_b, running} !== 3'b100) begin miscompares++; $display("FAIL fall_vs_press got=%b exp=100", {flag_a, active_b, running}); end
    endtask

    task automatic test_pause();
        do_reset();
        do_load(8'h10); do_start(); do_ticks(1);
        vectors++; if (time_a !== 16'h0959) begin miscompares++; $display("FAIL borrow_1000 got=%h exp=0959", time_a); end
        tick = 1'b1; pause = 1'b1; step(); tick = 1'b0; pause = 1'b0;
        vectors++; if (time_a !== 16'h0958) begin miscompares++; $display("FAIL pause_tick got=%h exp=0958", time_a); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL paused_running got=%b exp=0", running); end
        do_ticks(5);
        press_a = 1'b1; step(); press_a = 1'b0;
        vectors++; if ({time_a, active_b} !== {16'h0958, 1'b0}) begin miscompares++; $display("FAIL paused_hold got=%h exp=09580", {time_a, active_b}); end
        do_start(); do_ticks(1);
        vectors++; if ({time_a, time_b, running} !== {16'h0957, 16'h1000, 1'b1}) begin miscompares++; $display("FAIL resume got=%h exp=095710001", {time_a, time_b, running}); end
        pause = 1'b1; press_a = 1'b1; step(); pause = 1'b0; press_a = 1'b0;
        vectors++; if ({active_b, running} !== 2'b11) begin miscompares++; $display("FAIL pause_vs_press got=%b exp=11", {active_b, running}); end
    endtask

    task automatic test_load_reject();
        do_reset();
        do_load(8'h6A);
        vectors++; if ({time_a, time_b} !== 32'h0500_0500) begin miscompares++; $display("FAIL reject_6A got=%h exp=05000500", {time_a, time_b}); end
        do_load(8'h0C);
        vectors++; if ({time_a, time_b} !== 32'h0500_0500) begin miscompares++; $display("FAIL reject_0C got=%h exp=05000500", {time_a, time_b}); end
        do_load(8'h01); do_ticks(1);
        vectors++; if (time_a !== 16'h0100) begin miscompares++; $display("FAIL idle_tick got=%h exp=0100", time_a); end
        do_load(8'h00); do_start();
        vectors++; if ({time_a, running} !== {16'h0000, 1'b0}) begin miscompares++; $display("FAIL zero_start got=%h exp=00000", {time_a, running}); end
        do_ticks(1);
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL zero_stay_idle got=%b exp=0", running); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_load(8'h05); do_start();
        press_a = 1'b1; step(); press_a = 1'b0;
        do_ticks(48);
        vectors++; if ({time_a, time_b} !== 32'h0500_0412) begin miscompares++; $display("FAIL pre_reset got=%h exp=05000412", {time_a, time_b}); end
        do_reset();
        vectors++; if ({time_a, time_b} !== 32'h0500_0500) begin miscompares++; $display("FAIL mid_reset_times got=%h exp=05000500", {time_a, time_b}); end
        vectors++; if ({active_b, running, flag_a, flag_b} !== 4'b0000) begin miscompares++; $display("FAIL mid_reset_ctl got=%b exp=0000", {active_b, running, flag_a, flag_b}); end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_handover();
        test_flag();
        test_pause();
        test_load_reject();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
